// File: rtl/pmc_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pmc_shift_engine
//  Description : Serial shift engine between the PMC register file and the
//                pixel matrix. Shifts CHANNELS parallel words out MSB-first
//                on mtx_din while generating clk_sh, and assembles the matrix
//                return lines into din words.
//  Config macro: PMC_SHIFT_LOOPBACK_EN adds a 'loopback' input that makes
//                capture use mtx_din instead of mtx_dout.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmc_shift_engine #(
   parameter int CHANNELS = 16,
   parameter int WORD_W   = 32,
   parameter int CLK_DIV  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [$clog2(WORD_W)-1:0]   bit_cnt,
   input  logic [CHANNELS*WORD_W-1:0]  dout,
   output logic [CHANNELS*WORD_W-1:0]  din,
   output logic                        busy,
   output logic                        done,
   output logic                        clk_sh,
   output logic [CHANNELS-1:0]         mtx_din,
   input  logic [CHANNELS-1:0]         mtx_dout
`ifdef PMC_SHIFT_LOOPBACK_EN
   ,
   input  logic                        loopback
`endif
);

   // Phase counter spans one clk_sh half-period; bit counter must hold WORD_W.
   localparam int c_PH_W  = $clog2(CLK_DIV + 1);
   localparam int c_BIT_W = $clog2(WORD_W + 1);
   localparam logic [c_PH_W-1:0]  c_PH_LAST = c_PH_W'(CLK_DIV - 1);
   localparam logic [c_BIT_W-1:0] c_WORD_N  = c_BIT_W'(WORD_W);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [c_PH_W-1:0]          r_phase;
   logic [c_BIT_W-1:0]         r_bits_left;
   logic [WORD_W-1:0]          r_sh  [CHANNELS];
   logic [WORD_W-1:0]          r_cap [CHANNELS];
   logic [CHANNELS*WORD_W-1:0] r_din;

   logic [c_BIT_W-1:0]         w_n;
   logic [c_BIT_W-1:0]         w_shamt;
   logic                       w_phase_end;
   logic                       w_last_bit;
   logic [CHANNELS-1:0]        w_cap_src;

   // Requested length (0 encodes a full word) and the left shift that puts
   // bit N-1 of each word at the shift register MSB.
   assign w_n         = (bit_cnt == '0) ? c_WORD_N : c_BIT_W'(bit_cnt);
   assign w_shamt     = c_WORD_N - w_n;
   assign w_phase_end = (r_phase == c_PH_LAST);
   assign w_last_bit  = (r_bits_left == c_BIT_W'(1));
   assign din         = r_din;

`ifdef PMC_SHIFT_LOOPBACK_EN
   logic r_loopback;

   // Loopback selection is frozen for the whole transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_loopback <= 1'b0;
      else if (r_state == S_IDLE && start)
         r_loopback <= loopback;
   end

   assign w_cap_src = r_loopback ? mtx_din : mtx_dout;
`else
   assign w_cap_src = mtx_dout;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state and Moore outputs; mtx_din only carries data while shifting.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      clk_sh      = 1'b0;
      mtx_din     = '0;
      case (r_state)
         S_IDLE: begin
            if (start)
               w_state_nxt = S_LOW;
         end
         S_LOW: begin
            busy = 1'b1;
            for (int c = 0; c < CHANNELS; c++)
               mtx_din[c] = r_sh[c][WORD_W-1];
            if (w_phase_end)
               w_state_nxt = S_HIGH;
         end
         S_HIGH: begin
            busy   = 1'b1;
            clk_sh = 1'b1;
            for (int c = 0; c < CHANNELS; c++)
               mtx_din[c] = r_sh[c][WORD_W-1];
            if (w_phase_end)
               w_state_nxt = w_last_bit ? S_DONE : S_LOW;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Half-period phase counter and remaining-bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase     <= '0;
         r_bits_left <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_phase <= '0;
               if (start)
                  r_bits_left <= w_n;
            end
            S_LOW: begin
               r_phase <= w_phase_end ? '0 : r_phase + c_PH_W'(1);
            end
            S_HIGH: begin
               r_phase <= w_phase_end ? '0 : r_phase + c_PH_W'(1);
               if (w_phase_end)
                  r_bits_left <= r_bits_left - c_BIT_W'(1);
            end
            default: begin
               r_phase     <= '0;
               r_bits_left <= '0;
            end
         endcase
      end
   end

   // Output shift registers and capture registers. Capture happens on the
   // edge that raises clk_sh; the next output bit appears on the edge that
   // lowers it, so mtx_din is stable for a full half-period on each side.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_sh[c]  <= '0;
            r_cap[c] <= '0;
         end
      end else begin
         if (r_state == S_IDLE && start) begin
            for (int c = 0; c < CHANNELS; c++) begin
               r_sh[c]  <= dout[c*WORD_W +: WORD_W] << w_shamt;
               r_cap[c] <= '0;
            end
         end
         if (r_state == S_LOW && w_phase_end) begin
            for (int c = 0; c < CHANNELS; c++)
               r_cap[c] <= {r_cap[c][WORD_W-2:0], w_cap_src[c]};
         end
         if (r_state == S_HIGH && w_phase_end && !w_last_bit) begin
            for (int c = 0; c < CHANNELS; c++)
               r_sh[c] <= r_sh[c] << 1;
         end
      end
   end

   // Readback words are published only when a transfer completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_din <= '0;
      end else if (r_state == S_HIGH && w_phase_end && w_last_bit) begin
         for (int c = 0; c < CHANNELS; c++)
            r_din[c*WORD_W +: WORD_W] <= r_cap[c];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pmc_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pmc_shift_engine
//  Description : Directed self-checking bench for pmc_shift_engine. One
//                instance uses CLK_DIV=2, a second uses CLK_DIV=1 with a
//                behavioural matrix shift register on channel 5.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pmc_shift_engine;

   localparam int CH = 16;
   localparam int WW = 32;
   localparam int D0 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              start0, start1;
   logic [4:0]        bit_cnt0, bit_cnt1;
   logic [CH*WW-1:0]  dout0, dout1, din0, din1;
   logic              busy0, done0, clk_sh0, busy1, done1, clk_sh1;
   logic [CH-1:0]     mtx_din0, mtx_dout0, mtx_din1, mtx_dout1;
   logic [31:0]       mreg;
`ifdef PMC_SHIFT_LOOPBACK_EN
   logic              loopback0, loopback1;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   pmc_shift_engine #(.CHANNELS(CH), .WORD_W(WW), .CLK_DIV(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .bit_cnt(bit_cnt0),
      .dout(dout0), .din(din0), .busy(busy0), .done(done0),
      .clk_sh(clk_sh0), .mtx_din(mtx_din0), .mtx_dout(mtx_dout0)
`ifdef PMC_SHIFT_LOOPBACK_EN
      , .loopback(loopback0)
`endif
   );

   pmc_shift_engine #(.CHANNELS(CH), .WORD_W(WW), .CLK_DIV(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .bit_cnt(bit_cnt1),
      .dout(dout1), .din(din1), .busy(busy1), .done(done1),
      .clk_sh(clk_sh1), .mtx_din(mtx_din1), .mtx_dout(mtx_dout1)
`ifdef PMC_SHIFT_LOOPBACK_EN
      , .loopback(loopback1)
`endif
   );

   // 32-bit matrix register on channel 5: MSB drives the return line, and it
   // shifts in mtx_din shortly after each clk_sh rising edge.
   always_comb begin
      mtx_dout1    = '0;
      mtx_dout1[5] = mreg[31];
   end
   always @(posedge clk_sh1) begin
      #1;
      mreg = {mreg[30:0], mtx_din1[5]};
   end

   task automatic kick0();
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
   endtask

   // Samples dut0 for ncyc cycles from the first LOW cycle, optionally
   // re-pulsing start at cycles rp_a/rp_b, and tallies deviations from the
   // expected clk_sh and channel-0 mtx_din waveforms.
   task automatic observe(input int ncyc, input int rp_a, input int rp_b,
                          input int n, input logic [31:0] w,
                          output int busy_n, output int done_n, output int done_at,
                          output int sh_err, output int md_err,
                          output logic [31:0] d0, output logic [31:0] d1);
      int   span;
      logic exp_sh, exp_md;
      span = 2 * D0 * n;
      busy_n = 0; done_n = 0; done_at = -1; sh_err = 0; md_err = 0;
      d0 = '0; d1 = '0;
      for (int i = 0; i < ncyc; i++) begin
         if (i > 0) @(negedge clk);
         start0 = (i == rp_a) || (i == rp_b);
         exp_sh = (i < span) && (((i / D0) % 2) == 1);
         exp_md = (i < span) ? w[n - 1 - (i / (2 * D0))] : 1'b0;
         if (busy0) busy_n++;
         if (clk_sh0 !== exp_sh) sh_err++;
         if (mtx_din0[0] !== exp_md) md_err++;
         if (done0) begin
            done_n++;
            done_at = i;
            d0 = din0[31:0];
            d1 = din0[63:32];
         end
      end
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy0); else n_pass++;
      n_checks++; if (done0 !== 1'b0) $display("FAIL reset_done got %b want 0", done0); else n_pass++;
      n_checks++; if (clk_sh0 !== 1'b0) $display("FAIL reset_clk_sh got %b want 0", clk_sh0); else n_pass++;
      n_checks++; if (mtx_din0 !== '0) $display("FAIL reset_mtx_din got %h want 0", mtx_din0); else n_pass++;
      n_checks++; if (din0 !== '0) $display("FAIL reset_din0 got %h want 0", din0); else n_pass++;
      n_checks++; if (din1 !== '0 || busy1 !== 1'b0) $display("FAIL reset_dut1 din %h busy %b want 0", din1, busy1); else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_shift();
      int bn, dn, da, se, me;
      logic [31:0] d0, d1;
      dout0 = '0; dout0[31:0] = 32'hA; bit_cnt0 = 5'd4; mtx_dout0 = '1;
      kick0();
      observe(24, -1, -1, 4, 32'hA, bn, dn, da, se, me, d0, d1);
      n_checks++; if (bn !== 16) $display("FAIL basic_busy_cycles got %0d want 16", bn); else n_pass++;
      n_checks++; if (dn !== 1) $display("FAIL basic_done_count got %0d want 1", dn); else n_pass++;
      n_checks++; if (da !== 16) $display("FAIL basic_done_cycle got %0d want 16", da); else n_pass++;
      n_checks++; if (se !== 0) $display("FAIL basic_clk_sh_wave got %0d bad cycles want 0", se); else n_pass++;
      n_checks++; if (me !== 0) $display("FAIL basic_mtx_din_wave got %0d bad cycles want 0", me); else n_pass++;
      n_checks++; if (d0 !== 32'h0000000F) $display("FAIL basic_din0 got %h want 0000000f", d0); else n_pass++;
      n_checks++; if (d1 !== 32'h0000000F) $display("FAIL basic_din1 got %h want 0000000f", d1); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int bn, dn, da, se, me;
      logic [31:0] d0, d1;
      // Re-pulses during the run must not restart it.
      kick0();
      observe(24, 3, 10, 4, 32'hA, bn, dn, da, se, me, d0, d1);
      n_checks++; if (bn !== 16) $display("FAIL repulse_busy_cycles got %0d want 16", bn); else n_pass++;
      n_checks++; if (dn !== 1 || da !== 16) $display("FAIL repulse_done got count %0d at %0d want 1 at 16", dn, da); else n_pass++;
      n_checks++; if (se !== 0 || me !== 0) $display("FAIL repulse_waves got %0d/%0d bad want 0/0", se, me); else n_pass++;
      n_checks++; if (d0 !== 32'h0000000F) $display("FAIL repulse_din0 got %h want 0000000f", d0); else n_pass++;
      // A start during DONE is dropped.
      kick0();
      observe(34, 16, -1, 4, 32'hA, bn, dn, da, se, me, d0, d1);
      n_checks++; if (bn !== 16) $display("FAIL done_start_busy got %0d want 16", bn); else n_pass++;
      n_checks++; if (dn !== 1) $display("FAIL done_start_done got %0d want 1", dn); else n_pass++;
      // A fresh start from IDLE is accepted.
      kick0();
      observe(20, -1, -1, 4, 32'hA, bn, dn, da, se, me, d0, d1);
      n_checks++; if (dn !== 1 || da !== 16) $display("FAIL after_done_run got count %0d at %0d want 1 at 16", dn, da); else n_pass++;
   endtask

   task automatic test_full_word();
      int bn = 0, dn = 0, pulses = 0;
      logic prev = 1'b0;
      dout1 = '0; dout1[5*32 +: 32] = 32'h12345678; bit_cnt1 = 5'd0;
      mreg = 32'hDEADBEEF;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (i > 0) @(negedge clk);
         if (busy1) bn++;
         if (done1) dn++;
         if (clk_sh1 && !prev) pulses++;
         prev = clk_sh1;
      end
      n_checks++; if (bn !== 64) $display("FAIL full_busy_cycles got %0d want 64", bn); else n_pass++;
      n_checks++; if (pulses !== 32) $display("FAIL full_clk_sh_pulses got %0d want 32", pulses); else n_pass++;
      n_checks++; if (dn !== 1) $display("FAIL full_done_count got %0d want 1", dn); else n_pass++;
      n_checks++; if (din1[5*32 +: 32] !== 32'hDEADBEEF) $display("FAIL full_din5 got %h want deadbeef", din1[5*32 +: 32]); else n_pass++;
      n_checks++; if (mreg !== 32'h12345678) $display("FAIL full_matrix_reg got %h want 12345678", mreg); else n_pass++;
      n_checks++; if (din1[31:0] !== 32'h0) $display("FAIL full_din0 got %h want 0", din1[31:0]); else n_pass++;
   endtask

   task automatic test_reset_mid_shift();
      int bn, dn, da, se, me;
      logic [31:0] d0, d1;
      dout0 = '1; bit_cnt0 = 5'd16; mtx_dout0 = '1;
      kick0();
      for (int i = 0; i < 30; i++) @(negedge clk);
      // Cycle 30 is the HIGH half of bit index 7.
      n_checks++; if (clk_sh0 !== 1'b1 || mtx_din0[0] !== 1'b1) $display("FAIL midrst_pre got clk_sh %b din %b want 1 1", clk_sh0, mtx_din0[0]); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (busy0 !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy0); else n_pass++;
      n_checks++; if (clk_sh0 !== 1'b0) $display("FAIL midrst_clk_sh got %b want 0", clk_sh0); else n_pass++;
      n_checks++; if (mtx_din0 !== '0) $display("FAIL midrst_mtx_din got %h want 0", mtx_din0); else n_pass++;
      n_checks++; if (din0 !== '0) $display("FAIL midrst_din got %h want 0", din0); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dout0 = '0; dout0[31:0] = 32'h1234; mtx_dout0 = 16'h0001;
      kick0();
      observe(72, -1, -1, 16, 32'h1234, bn, dn, da, se, me, d0, d1);
      n_checks++; if (bn !== 64) $display("FAIL postrst_busy got %0d want 64", bn); else n_pass++;
      n_checks++; if (dn !== 1 || da !== 64) $display("FAIL postrst_done got count %0d at %0d want 1 at 64", dn, da); else n_pass++;
      n_checks++; if (se !== 0 || me !== 0) $display("FAIL postrst_waves got %0d/%0d bad want 0/0", se, me); else n_pass++;
      n_checks++; if (d0 !== 32'h0000FFFF || d1 !== 32'h0) $display("FAIL postrst_din got %h %h want 0000ffff 00000000", d0, d1); else n_pass++;
   endtask

`ifdef PMC_SHIFT_LOOPBACK_EN
   task automatic test_loopback();
      int bn, dn, da, se, me;
      logic [31:0] d0, d1, e;
      mtx_dout0 = '0; loopback0 = 1'b1; bit_cnt0 = 5'd16;
      for (int c = 0; c < CH; c++) dout0[c*32 +: 32] = 32'(c) * 32'h01010101;
      kick0();
      loopback0 = 1'b0;
      observe(72, -1, -1, 16, dout0[31:0], bn, dn, da, se, me, d0, d1);
      n_checks++; if (dn !== 1) $display("FAIL loop_done got %0d want 1", dn); else n_pass++;
      for (int c = 0; c < CH; c++) begin
         e = (32'(c) * 32'h01010101) & 32'h0000FFFF;
         n_checks++;
         if (din0[c*32 +: 32] !== e) $display("FAIL loop_din ch %0d got %h want %h", c, din0[c*32 +: 32], e);
         else n_pass++;
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
      bit_cnt0 = '0; bit_cnt1 = '0; dout0 = '0; dout1 = '0;
      mtx_dout0 = '0; mreg = '0;
`ifdef PMC_SHIFT_LOOPBACK_EN
      loopback0 = 1'b0; loopback1 = 1'b0;
`endif
      test_reset();
      test_basic_shift();
      test_back_to_back();
      test_full_word();
      test_reset_mid_shift();
`ifdef PMC_SHIFT_LOOPBACK_EN
      test_loopback();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
